// File: rtl/func_sweep_ctrl.sv
// rtl/func_sweep_ctrl.sv - exhaustive 3-input function sweeper with truth-table compare
module func_sweep_ctrl #(
  parameter int SETTLE = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [7:0] expected,
  input  logic       F,
  output logic [2:0] abc,
  output logic       busy,
  output logic       done,
  output logic [7:0] truth,
  output logic [7:0] mismatch,
  output logic [3:0] err_cnt,
  output logic       pass
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_SETTLE = 2'd1;
  localparam logic [1:0] S_SAMPLE = 2'd2;
  localparam logic [1:0] S_FINISH = 2'd3;
  localparam logic [3:0] RELOAD   = 4'(SETTLE - 1);

  logic [1:0] r_state;
  logic [3:0] r_cnt;
  logic [2:0] r_abc;
  logic [7:0] r_truth;
  logic [7:0] r_exp;
  logic [7:0] r_mismatch;
  logic [3:0] r_err_cnt;
  logic       r_pass;

  logic [7:0] w_truth_next;
  logic [7:0] w_mis;
  logic [3:0] w_pop;

  // Results for the last vector are folded in on the same edge that samples it,
  // so they are already complete in the done cycle.
  always_comb begin
    w_truth_next        = r_truth;
    w_truth_next[r_abc] = F;
    w_mis               = w_truth_next ^ r_exp;
    w_pop               = 4'd0;
    for (int i = 0; i < 8; i++) begin
      w_pop = w_pop + {3'b000, w_mis[i]};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_cnt      <= 4'd0;
      r_abc      <= 3'd0;
      r_truth    <= 8'd0;
      r_exp      <= 8'd0;
      r_mismatch <= 8'd0;
      r_err_cnt  <= 4'd0;
      r_pass     <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_exp      <= expected;
            r_truth    <= 8'd0;
            r_abc      <= 3'd0;
            r_cnt      <= RELOAD;
            r_mismatch <= 8'd0;
            r_err_cnt  <= 4'd0;
            r_pass     <= 1'b0;
            r_state    <= S_SETTLE;
          end
        end
        S_SETTLE: begin
          if (r_cnt != 4'd0) begin
            r_cnt <= r_cnt - 4'd1;
          end else begin
            r_state <= S_SAMPLE;
          end
        end
        S_SAMPLE: begin
          r_truth <= w_truth_next;
          if (r_abc == 3'd7) begin
            r_mismatch <= w_mis;
            r_err_cnt  <= w_pop;
            r_pass     <= (w_pop == 4'd0);
            r_state    <= S_FINISH;
          end else begin
            r_abc   <= r_abc + 3'd1;
            r_cnt   <= RELOAD;
            r_state <= S_SETTLE;
          end
        end
        S_FINISH: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign abc      = r_abc;
  assign busy     = (r_state == S_SETTLE) || (r_state == S_SAMPLE);
  assign done     = (r_state == S_FINISH);
  assign truth    = r_truth;
  assign mismatch = r_mismatch;
  assign err_cnt  = r_err_cnt;
  assign pass     = r_pass;

endmodule

// File: tb/tb_func_sweep_ctrl.sv
// tb/tb_func_sweep_ctrl.sv - directed self-checking bench for func_sweep_ctrl
module tb_func_sweep_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start1 = 1'b0;
  logic       start3 = 1'b0;
  logic [7:0] exp1 = 8'd0;
  logic [7:0] exp3 = 8'd0;
  logic       f1, f3;
  int         mode = 0;

  logic [2:0] abc1, abc3;
  logic       busy1, busy3, done1, done3, pass1, pass3;
  logic [7:0] truth1, truth3, mis1, mis3;
  logic [3:0] err1, err3;

  logic [2:0] d1a = 3'd0, d1b = 3'd0, d1c = 3'd0;
  logic [2:0] d3a = 3'd0, d3b = 3'd0, d3c = 3'd0;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  function automatic logic maj(input logic [2:0] v);
    return (v[2] & v[1]) | (v[2] & v[0]) | (v[1] & v[0]);
  endfunction

  // Slow unit: F follows abc with three cycles of delay
  always @(posedge clk) begin
    d1a <= abc1; d1b <= d1a; d1c <= d1b;
    d3a <= abc3; d3b <= d3a; d3c <= d3b;
  end

  assign f1 = (mode == 0) ? maj(abc1) : (mode == 1) ? 1'b0 : ^d1c;
  assign f3 = ^d3c;

  func_sweep_ctrl #(.SETTLE(1)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .expected(exp1), .F(f1),
    .abc(abc1), .busy(busy1), .done(done1), .truth(truth1),
    .mismatch(mis1), .err_cnt(err1), .pass(pass1)
  );

  func_sweep_ctrl #(.SETTLE(3)) dut3 (
    .clk(clk), .rst(rst), .start(start3), .expected(exp3), .F(f3),
    .abc(abc3), .busy(busy3), .done(done3), .truth(truth3),
    .mismatch(mis3), .err_cnt(err3), .pass(pass3)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h", tag, got, want);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    rst = 1'b1;
    tick;
    tick;
    rst = 1'b0;
  endtask

  task automatic sweep1(input logic [7:0] e, output int done_cyc, output int seq_err);
    int cyc;
    seq_err  = 0;
    done_cyc = -1;
    exp1     = e;
    start1   = 1'b1;
    tick;
    start1   = 1'b0;
    cyc      = 1;
    while (cyc < 200) begin
      if (done1) begin
        done_cyc = cyc;
        if (busy1) seq_err++;
        break;
      end
      if (!busy1 || abc1 != 3'((cyc - 1) / 2)) seq_err++;
      tick;
      cyc++;
    end
  endtask

  task automatic sweep3(input logic [7:0] e, output int done_cyc, output int seq_err);
    int cyc;
    seq_err  = 0;
    done_cyc = -1;
    exp3     = e;
    start3   = 1'b1;
    tick;
    start3   = 1'b0;
    cyc      = 1;
    while (cyc < 300) begin
      if (done3) begin
        done_cyc = cyc;
        if (busy3) seq_err++;
        break;
      end
      if (!busy3 || abc3 != 3'((cyc - 1) / 4)) seq_err++;
      tick;
      cyc++;
    end
  endtask

  initial begin
    int dc, se, ndone, n;
    #1;
    do_reset;
    for (int i = 0; i < 5; i++) begin
      check("rst_abc", abc1, 0);
      check("rst_busy", busy1, 0);
      check("rst_done", done1, 0);
      check("rst_truth", truth1, 0);
      check("rst_pass", pass1, 0);
      tick;
    end

    // majority unit, correct expectation
    mode = 0;
    sweep1(8'hE8, dc, se);
    check("maj_done_cyc", dc, 17);
    check("maj_seq", se, 0);
    check("maj_truth", truth1, 8'hE8);
    check("maj_mis", mis1, 0);
    check("maj_err", err1, 0);
    check("maj_pass", pass1, 1);
    tick;
    check("maj_idle_busy", busy1, 0);
    check("maj_idle_done", done1, 0);
    tick; tick;
    check("maj_hold_truth", truth1, 8'hE8);
    check("maj_hold_abc", abc1, 7);

    // stuck-at-0 unit
    mode = 1;
    sweep1(8'hE8, dc, se);
    check("stuck_done_cyc", dc, 17);
    check("stuck_truth", truth1, 8'h00);
    check("stuck_mis", mis1, 8'hE8);
    check("stuck_err", err1, 4);
    check("stuck_pass", pass1, 0);
    tick; tick; tick;

    // slow parity unit on a too-short settle time
    mode = 2;
    sweep1(8'h96, dc, se);
    check("slow1_truth", truth1, 8'h2D);
    check("slow1_err", err1, 6);
    check("slow1_pass", pass1, 0);
    tick; tick;

    // slow parity unit with SETTLE=3
    sweep3(8'h96, dc, se);
    check("slow3_done_cyc", dc, 33);
    check("slow3_seq", se, 0);
    check("slow3_truth", truth3, 8'h96);
    check("slow3_pass", pass3, 1);
    tick; tick;

    // start held high through the sweep
    mode   = 0;
    exp1   = 8'hE8;
    start1 = 1'b1;
    tick;
    ndone = 0;
    se    = 0;
    for (int cyc = 1; cyc <= 19; cyc++) begin
      if (cyc <= 16 && (!busy1 || done1 || abc1 != 3'((cyc - 1) / 2))) se++;
      if (done1) ndone++;
      if (cyc == 17) check("hold_done17", done1, 1);
      if (cyc == 18) check("hold_busy18", busy1, 0);
      if (cyc == 19) begin
        check("hold_busy19", busy1, 1);
        check("hold_abc19", abc1, 0);
      end
      if (cyc < 19) tick;
    end
    start1 = 1'b0;
    check("hold_ndone", ndone, 1);
    check("hold_seq", se, 0);
    n = 0;
    while (!done1 && n < 40) begin
      tick;
      n++;
    end
    check("hold_second_done", done1, 1);
    check("hold_second_truth", truth1, 8'hE8);
    tick; tick;

    // reset in the middle of a sweep
    exp1   = 8'hE8;
    start1 = 1'b1;
    tick;
    start1 = 1'b0;
    n = 0;
    while (abc1 != 3'd4 && n < 40) begin
      tick;
      n++;
    end
    check("mid_reached_abc4", abc1, 4);
    check("mid_truth_pre", truth1, 8'h08);
    rst = 1'b1;
    tick;
    rst = 1'b0;
    check("mid_abc", abc1, 0);
    check("mid_busy", busy1, 0);
    check("mid_truth", truth1, 0);
    ndone = 0;
    for (int i = 0; i < 40; i++) begin
      if (done1) ndone++;
      tick;
    end
    check("mid_no_done", ndone, 0);
    sweep1(8'hE8, dc, se);
    check("mid_after_done_cyc", dc, 17);
    check("mid_after_seq", se, 0);
    check("mid_after_pass", pass1, 1);
    check("mid_after_truth", truth1, 8'hE8);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
